// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 datapath widths and MEM-stage state encoding
package legv8_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {IDLE, WAIT, FAULT} mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; bubble clears controls and holds data
module mem_wb_reg #(
  parameter int DATA_W = legv8_pkg::DATA_W,
  parameter int REG_W = legv8_pkg::REG_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bubble,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic              regwrite,
  input  logic              memtoreg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_regwrite,
  output logic              wb_memtoreg
);
  logic [DATA_W-1:0] read_data_d, read_data_q, alu_result_d, alu_result_q;
  logic [REG_W-1:0] write_reg_d, write_reg_q;
  logic regwrite_d, regwrite_q, memtoreg_d, memtoreg_q;
  always_comb begin
    read_data_d = bubble ? read_data_q : read_data;
    alu_result_d = bubble ? alu_result_q : alu_result;
    write_reg_d = bubble ? write_reg_q : write_reg;
    regwrite_d = ~bubble & regwrite;
    memtoreg_d = ~bubble & memtoreg;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q <= '0;
      alu_result_q <= '0;
      write_reg_q <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q <= write_reg_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end
  assign wb_read_data = read_data_q;
  assign wb_alu_result = alu_result_q;
  assign wb_write_reg = write_reg_q;
  assign wb_regwrite = regwrite_q;
  assign wb_memtoreg = memtoreg_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LEGv8 MEM stage with variable-latency dmem handshake, stall, branch resolve and MEM/WB
module mem_stage #(
  parameter int DATA_W = legv8_pkg::DATA_W,
  parameter int REG_W = legv8_pkg::REG_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] read2,
  input  logic [REG_W-1:0]  write_reg,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic              memtoreg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_fault,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_regwrite,
  output logic              wb_memtoreg
);
  import legv8_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  mem_state_t state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic access, misaligned, bubble;
  logic [DATA_W-1:0] read_data;
  always_comb begin
    access = (memread | memwrite) & (state_q != FAULT);
    misaligned = access & (alu_result[2:0] != 3'd0);
    dmem_req = reset_n & ((state_q == WAIT) | (access & ~misaligned));
    dmem_we = memwrite;
    dmem_addr = alu_result;
    dmem_wdata = read2;
    stall = dmem_req & ~dmem_ready;
    pcsrc = branch & zero & (state_q != FAULT);
    branch_target = add_result;
    mem_fault = state_q == FAULT;
    bubble = stall | misaligned | (state_q == FAULT);
    read_data = (memread & ~memwrite & dmem_req & dmem_ready) ? dmem_rdata : '0;
    state_d = misaligned ? FAULT :
              (state_q == IDLE) ? (stall ? WAIT : IDLE) :
              (state_q == WAIT) ? (dmem_ready ? IDLE : (cnt_q == CW'(TIMEOUT)) ? FAULT : WAIT) :
              state_q;
    cnt_d = (state_d == WAIT) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mem_wb (
    .clock(clock),
    .reset_n(reset_n),
    .bubble(bubble),
    .alu_result(alu_result),
    .read_data(read_data),
    .write_reg(write_reg),
    .regwrite(regwrite),
    .memtoreg(memtoreg),
    .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result),
    .wb_write_reg(wb_write_reg),
    .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with TIMEOUT = 4
module tb_mem_stage;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [63:0] add_result = '0, alu_result = '0, read2 = '0, dmem_rdata = '0;
  logic [4:0] write_reg = '0;
  logic zero = 0, branch = 0, memread = 0, memwrite = 0, regwrite = 0, memtoreg = 0, dmem_ready = 0;
  logic dmem_req, dmem_we, stall, pcsrc, mem_fault, wb_regwrite, wb_memtoreg;
  logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
  logic [4:0] wb_write_reg;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  mem_stage #(.DATA_W(64), .REG_W(5), .TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .add_result(add_result), .alu_result(alu_result),
    .zero(zero), .read2(read2), .write_reg(write_reg), .branch(branch), .memread(memread),
    .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .mem_fault(mem_fault), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_write_reg(wb_write_reg), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle_inputs();
    {branch, zero, memread, memwrite, regwrite, memtoreg, dmem_ready} = '0;
    alu_result = '0;
    read2 = '0;
    write_reg = '0;
    dmem_rdata = '0;
  endtask
  initial begin
    #3 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    // zero-wait load
    memread = 1; alu_result = 64'h40; regwrite = 1; memtoreg = 1; write_reg = 5'd7;
    dmem_ready = 1; dmem_rdata = 64'hDEADBEEF;
    #1;
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_stall", stall, 0);
    tick();
    chk("ld_wb_rdata", wb_read_data, 64'hDEADBEEF);
    chk("ld_wb_alu", wb_alu_result, 64'h40);
    chk("ld_wb_reg", wb_write_reg, 7);
    chk("ld_wb_regwrite", wb_regwrite, 1);
    chk("ld_wb_memtoreg", wb_memtoreg, 1);
    // 3-wait store
    idle_inputs();
    memwrite = 1; alu_result = 64'h18; read2 = 64'h55; regwrite = 1; write_reg = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", stall, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 64'h18);
      chk("st_wdata", dmem_wdata, 64'h55);
      tick();
      chk("st_bubble_regwrite", wb_regwrite, 0);
      chk("st_bubble_hold", wb_alu_result, 64'h40);
    end
    dmem_ready = 1;
    #1;
    chk("st_req_last", dmem_req, 1);
    chk("st_stall_last", stall, 0);
    tick();
    chk("st_wb_regwrite", wb_regwrite, 1);
    chk("st_wb_alu", wb_alu_result, 64'h18);
    chk("st_wb_rdata", wb_read_data, 0);
    // branch
    idle_inputs();
    branch = 1; zero = 1; add_result = 64'h100;
    #1;
    chk("br_pcsrc", pcsrc, 1);
    chk("br_target", branch_target, 64'h100);
    chk("br_stall", stall, 0);
    chk("br_req", dmem_req, 0);
    zero = 0;
    #1;
    chk("br_nz_pcsrc", pcsrc, 0);
    tick();
    // read and write together: write wins
    idle_inputs();
    memread = 1; memwrite = 1; alu_result = 64'h20; dmem_ready = 1; dmem_rdata = 64'h1234; regwrite = 1;
    #1;
    chk("rw_we", dmem_we, 1);
    tick();
    chk("rw_wb_rdata", wb_read_data, 0);
    chk("rw_wb_alu", wb_alu_result, 64'h20);
    // reset mid-WAIT
    idle_inputs();
    memread = 1; alu_result = 64'h30;
    tick();
    chk("mw_req", dmem_req, 1);
    chk("mw_stall", stall, 1);
    reset_n = 0;
    #1;
    chk("mw_rst_req", dmem_req, 0);
    chk("mw_rst_wb_regwrite", wb_regwrite, 0);
    chk("mw_rst_wb_alu", wb_alu_result, 0);
    chk("mw_rst_wb_rdata", wb_read_data, 0);
    chk("mw_rst_fault", mem_fault, 0);
    idle_inputs();
    tick();
    reset_n = 1;
    #1;
    chk("mw_post_stall", stall, 0);
    // timeout after 4 WAIT cycles
    memread = 1; alu_result = 64'h48; regwrite = 1;
    #1;
    chk("to_req_idle", dmem_req, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_req_wait", dmem_req, 1);
      chk("to_fault_wait", mem_fault, 0);
      tick();
    end
    chk("to_req_drop", dmem_req, 0);
    chk("to_fault", mem_fault, 1);
    chk("to_stall", stall, 0);
    chk("to_wb_regwrite", wb_regwrite, 0);
    branch = 1; zero = 1;
    #1;
    chk("to_pcsrc", pcsrc, 0);
    tick();
    chk("to_fault_bubble", wb_regwrite, 0);
    chk("to_fault_sticky", mem_fault, 1);
    // misaligned access
    idle_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
    regwrite = 1; alu_result = 64'h77;
    tick();
    chk("ma_pre_regwrite", wb_regwrite, 1);
    chk("ma_pre_alu", wb_alu_result, 64'h77);
    memread = 1; alu_result = 64'h43;
    #1;
    chk("ma_req", dmem_req, 0);
    chk("ma_stall", stall, 0);
    chk("ma_fault_pre", mem_fault, 0);
    tick();
    chk("ma_fault", mem_fault, 1);
    chk("ma_wb_regwrite", wb_regwrite, 0);
    chk("ma_wb_alu_hold", wb_alu_result, 64'h77);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- LEGv8 pipelined CPU MEM stage, directly downstream of the EX/MEM pipeline register; consumes its fields.
- Performs data-memory access over a variable-latency req/ready handshake and stalls the pipeline while an access is outstanding.
- Resolves conditional branches (PCSrc) and owns the MEM/WB pipeline register feeding write-back.

Parameters:
DATA_W, 64, datapath/address width
REG_W, 5, register index width
TIMEOUT, 255, max WAIT cycles before a memory fault is declared (>=1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
add_result  in  DATA_W  branch target from EX/MEM
alu_result  in  DATA_W  memory address / ALU result
zero  in  1  ALU zero flag
read2  in  DATA_W  store data
write_reg  in  REG_W  destination register
branch, memread, memwrite  in  1 each  MEM controls
regwrite, memtoreg  in  1 each  WB controls
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  DATA_W  = alu_result
dmem_wdata  out  DATA_W  = read2
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  DATA_W  load data, valid when dmem_ready & ~dmem_we
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
pcsrc  out  1  take branch
branch_target  out  DATA_W  = add_result
mem_fault  out  1  sticky fault flag
wb_read_data, wb_alu_result  out  DATA_W  MEM/WB data
wb_write_reg  out  REG_W  MEM/WB destination
wb_regwrite, wb_memtoreg  out  1  MEM/WB controls

Behaviour:
- Interface: one clock (clock); reset_n is asynchronous and active-low.
- Reset: state IDLE, wait counter 0, mem_fault 0, all wb_* outputs 0. dmem_req drops immediately on reset assertion; reset during WAIT abandons the access, and memory discards it.
- access = (memread | memwrite) & state != FAULT. If memread and memwrite are both set, the write wins: dmem_we = 1 and the captured read data is 0.
- Misalignment: an access with alu_result[2:0] != 0 issues no request, sets mem_fault, and moves to FAULT at the next edge. That instruction enters MEM/WB as a bubble.
- IDLE:
  - Aligned access: dmem_req = 1 combinationally in the same cycle.
  - dmem_ready = 1 in that cycle: zero-wait completion; MEM/WB captures at the edge; state stays IDLE.
  - Otherwise: go to WAIT with counter = 1.
- WAIT:
  - dmem_req held at 1; address, data and we stay stable because upstream holds EX/MEM while stall is high.
  - dmem_ready = 1: capture into MEM/WB, return to IDLE, clear counter.
  - Else if counter == TIMEOUT: drop req, set mem_fault, go to FAULT, insert a bubble.
  - Else: counter increments. Counter width is clog2(TIMEOUT+1); it never wraps.
- FAULT: sticky until reset. No requests are issued; stall = 0; pcsrc = 0; every MEM/WB load is a bubble.
- stall = dmem_req & ~dmem_ready (combinational). It is never asserted in IDLE without an access, or in FAULT.
- MEM/WB register, on each rising edge:
  - stall = 1: load a bubble (wb_regwrite = 0, wb_memtoreg = 0; data fields hold).
  - else: load wb_alu_result = alu_result, wb_write_reg, wb_regwrite, wb_memtoreg; wb_read_data = dmem_rdata for a completed load, else 0.
- pcsrc = branch & zero & state != FAULT (combinational). branch_target = add_result. A branch with no memory op never stalls.
- dmem_ready while dmem_req = 0 is ignored.

Decomposition:
- Shared package legv8_pkg holds DATA_W, REG_W, and the mem_state_t enum {IDLE, WAIT, FAULT}.
- One sub-module, mem_wb_reg: the MEM/WB register with a bubble input and async active-low reset.
- FSM, counter and handshake stay in mem_stage.

Test Plan:
- Reset: assert reset_n = 0 mid-WAIT -> dmem_req = 0 in the same cycle; all wb_* = 0, state IDLE, mem_fault = 0.
- Zero-wait load: memread = 1, alu_result = 0x40, regwrite = 1, memtoreg = 1, dmem_ready = 1 with rdata 0xDEADBEEF -> stall never 1; next edge wb_read_data = 0xDEADBEEF, wb_alu_result = 0x40.
- 3-wait store: memwrite = 1, addr 0x18, read2 = 0x55, ready on the 4th cycle -> stall = 1 for 3 cycles; dmem_we = 1 and addr/wdata stable throughout; three bubbles (wb_regwrite = 0) into MEM/WB, then normal capture.
- Timeout with TIMEOUT = 4: load, ready never asserted -> after 4 WAIT cycles dmem_req falls and mem_fault = 1; a subsequent branch with zero = 1 gives pcsrc = 0.
- Misaligned: memread with addr 0x43 -> dmem_req never asserted, mem_fault = 1 after the edge, bubble in MEM/WB.
- Branch: branch = 1, zero = 1, add_result = 0x100 -> pcsrc = 1, branch_target = 0x100, stall = 0; with zero = 0 -> pcsrc = 0.
